// File: rtl/pattern_checker.sv
// pattern_checker
//   Self-checking sequencer for a combinational DUT. It walks a pattern ROM
//   and, for each entry:
//     - drives the stimulus to the DUT;
//     - waits SETTLE cycles;
//     - compares the DUT response against the golden value, under a per-bit
//       compare mask.
//   It accumulates a pass score, a fail count and the index of the first
//   failing pattern, and flags all-pass at the end of the run.
//
// Ports
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   start              begin a run; sampled only in IDLE
//   abort              cancel a run in APPLY/SETTLE/CHECK
//   pat_addr           ROM address
//   pat_vec            stimulus at pat_addr (combinational ROM read)
//   pat_gold           golden response at pat_addr
//   pat_mask           per-bit compare enable (1 = compare)
//   dut_in             registered DUT stimulus
//   dut_out            DUT response
//   busy               high in APPLY/SETTLE/CHECK
//   done               one-cycle pulse at run completion
//   score, fail_cnt    patterns passed / failed
//   first_fail_idx     index of first failing pattern
//   first_fail_vld     at least one failure recorded
//   all_pass           score == NUM_PAT, valid from done onward
//   aborted            last run was aborted
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | waiting for start; results of the last run are held
// S_APPLY  | latch stimulus/golden/mask from the ROM, load settle timer
// S_SETTLE | settle timer counts down SETTLE cycles
// S_CHECK  | compare DUT response, update counters, advance address
// S_DONE   | pulse done, resolve all_pass, return to IDLE
module pattern_checker #(
  parameter int IN_W    = 5,
  parameter int OUT_W   = 2,
  parameter int NUM_PAT = 5,
  parameter int SETTLE  = 1,
  parameter int AW      = 3,
  parameter int CW      = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic [AW-1:0]    pat_addr,
  input  logic [IN_W-1:0]  pat_vec,
  input  logic [OUT_W-1:0] pat_gold,
  input  logic [OUT_W-1:0] pat_mask,
  output logic [IN_W-1:0]  dut_in,
  input  logic [OUT_W-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    score,
  output logic [CW-1:0]    fail_cnt,
  output logic [AW-1:0]    first_fail_idx,
  output logic             first_fail_vld,
  output logic             all_pass,
  output logic             aborted
);

  // Timer is at least one bit wide even when SETTLE is 0 or 1.
  localparam int SW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  state_t           state;
  logic [OUT_W-1:0] gold_r;
  logic [OUT_W-1:0] mask_r;
  logic [SW-1:0]    settle_cnt;
  logic             pass;

  // Bits with mask 0 never contribute a mismatch.
  assign pass = (((dut_out ^ gold_r) & mask_r) == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      gold_r         <= '0;
      mask_r         <= '0;
      settle_cnt     <= '0;
      pat_addr       <= '0;
      dut_in         <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      score          <= '0;
      fail_cnt       <= '0;
      first_fail_idx <= '0;
      first_fail_vld <= 1'b0;
      all_pass       <= 1'b0;
      aborted        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state          <= S_APPLY;
            busy           <= 1'b1;
            pat_addr       <= '0;
            score          <= '0;
            fail_cnt       <= '0;
            first_fail_idx <= '0;
            first_fail_vld <= 1'b0;
            all_pass       <= 1'b0;
            aborted        <= 1'b0;
          end
        end

        S_APPLY: begin
          if (abort) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            aborted  <= 1'b1;
            all_pass <= 1'b0;
          end else begin
            dut_in     <= pat_vec;
            gold_r     <= pat_gold;
            mask_r     <= pat_mask;
            settle_cnt <= SW'(SETTLE);
            state      <= (SETTLE > 0) ? S_SETTLE : S_CHECK;
          end
        end

        S_SETTLE: begin
          if (abort) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            aborted  <= 1'b1;
            all_pass <= 1'b0;
          end else begin
            settle_cnt <= settle_cnt - SW'(1);
            if (settle_cnt == SW'(1)) begin
              state <= S_CHECK;
            end
          end
        end

        S_CHECK: begin
          // Abort takes priority: counters stay frozen this cycle.
          if (abort) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            aborted  <= 1'b1;
            all_pass <= 1'b0;
          end else begin
            if (pass) begin
              score <= score + CW'(1);
            end else begin
              fail_cnt <= fail_cnt + CW'(1);
              if (!first_fail_vld) begin
                first_fail_idx <= pat_addr;
                first_fail_vld <= 1'b1;
              end
            end
            if (pat_addr == AW'(NUM_PAT - 1)) begin
              state <= S_DONE;
              busy  <= 1'b0;
            end else begin
              pat_addr <= pat_addr + AW'(1);
              state    <= S_APPLY;
            end
          end
        end

        S_DONE: begin
          done     <= 1'b1;
          all_pass <= (score == CW'(NUM_PAT));
          state    <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/pattern_checker.md
Name: pattern_checker

Overview:
- Synthesizable, parameterised self-checking test sequencer for a combinational DUT, such as the ISCAS c17 netlist.
- Reads stimulus, golden and mask vectors from an external pattern ROM. Drives the DUT inputs, waits a settle time, then compares the DUT outputs against golden.
- Accumulates pass score, fail count and first-failing index, and flags all-pass.
- Replaces the hand-written per-pattern check sequences in the circuit benches.

Parameters:
- IN_W, 5, DUT input width.
- OUT_W, 2, DUT output width.
- NUM_PAT, 5, number of patterns in the ROM (>=1).
- SETTLE, 1, cycles between driving dut_in and sampling dut_out (>=0).
- AW, 3, pattern address width; must satisfy 2**AW >= NUM_PAT.
- CW, 3, score/count width; must satisfy 2**CW > NUM_PAT.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a run; sampled only in IDLE.
- abort  in  1  cancel a run in progress.
- pat_addr  out  AW  ROM address.
- pat_vec  in  IN_W  stimulus at pat_addr; combinational read, valid the same cycle.
- pat_gold  in  OUT_W  golden response at pat_addr.
- pat_mask  in  OUT_W  per-bit compare enable; 1 = compare.
- dut_in  out  IN_W  registered DUT stimulus.
- dut_out  in  OUT_W  DUT response.
- busy  out  1  high in APPLY/SETTLE/CHECK.
- done  out  1  one-cycle pulse at run completion.
- score  out  CW  patterns passed.
- fail_cnt  out  CW  patterns failed.
- first_fail_idx  out  AW  index of first failing pattern.
- first_fail_vld  out  1  at least one failure recorded.
- all_pass  out  1  score==NUM_PAT; valid from done onward.
- aborted  out  1  last run was aborted.

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE.
  - All outputs 0: pat_addr, dut_in, busy, done, score, fail_cnt, first_fail_idx, first_fail_vld, all_pass, aborted.
  - Reset mid-run discards the run immediately and asserts no done.
- FSM states: IDLE, APPLY, SETTLE, CHECK, DONE.
- IDLE:
  - start=1 -> APPLY next cycle.
  - On that edge: pat_addr=0; score, fail_cnt, first_fail_idx, first_fail_vld, all_pass and aborted all cleared.
- APPLY (1 cycle):
  - Register dut_in<=pat_vec, gold_r<=pat_gold, mask_r<=pat_mask, settle_cnt<=SETTLE.
  - Next state is SETTLE if SETTLE>0, else CHECK.
- SETTLE (exactly SETTLE cycles):
  - settle_cnt decrements each cycle.
  - Go to CHECK when settle_cnt==1.
- CHECK (1 cycle):
  - pass = ((dut_out ^ gold_r) & mask_r) == 0.
  - Pass -> score+1. Fail -> fail_cnt+1; if first_fail_vld==0, latch first_fail_idx=pat_addr and set first_fail_vld.
  - If pat_addr==NUM_PAT-1 -> DONE; else pat_addr+1 -> APPLY.
- DONE (1 cycle):
  - done=1, all_pass<=(score==NUM_PAT), then -> IDLE.
  - start in the DONE cycle is ignored.
- Latency:
  - Per pattern: SETTLE+2 cycles.
  - done is asserted 1+NUM_PAT*(SETTLE+2) cycles after the start sample edge; 16 cycles at the defaults.
- Holding results:
  - score, fail_cnt, first_fail_*, all_pass and dut_in hold their values in IDLE until the next accepted start.
- Invariant: score+fail_cnt == number of CHECK cycles executed.
- start while busy: ignored, no restart.
- abort:
  - Honoured in APPLY/SETTLE/CHECK: next state IDLE, aborted=1, no done pulse, all_pass=0. Counters freeze at their current values.
  - abort in IDLE/DONE is ignored.
  - Simultaneous abort and CHECK: abort wins and no score update occurs that cycle.
- Mask: mask=0 on every bit makes the pattern pass unconditionally.
- Arithmetic: counters never wrap, because CW guarantees headroom.

Test Plan:
- Reset: assert rst_n=0 mid-run at pattern 2 -> all outputs 0 asynchronously, busy=0; release and idle -> no done.
- Golden c17 DUT, ROM {00000->00, 10101->11, 01010->11, 11011->11, 11111->10}, masks 11, SETTLE=1; pulse start -> done exactly 16 cycles later; score=5, fail_cnt=0, all_pass=1, first_fail_vld=0.
- c17 with gat_out23 stuck-at-1, same ROM -> patterns 0 and 4 fail; score=3, fail_cnt=2, first_fail_idx=0, first_fail_vld=1, all_pass=0.
- Same stuck DUT, pat_mask=10 for all patterns -> score=5, all_pass=1. SETTLE=0 variant -> done 11 cycles after start.
- Abort asserted during SETTLE of pattern 2 -> IDLE next cycle, aborted=1, no done, score=2. Restart -> aborted=0 and full correct result.
- start held high for the whole run, and again in the DONE cycle -> exactly one run and one done pulse; a new run begins only on a start seen in IDLE.
